// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arithmetic ops, iterative shift-add multiply.
// One operation in flight; the result is held until the consumer takes it.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOR  = 5'h06;
    localparam logic [4:0] OP_SLT  = 5'h07;
    localparam logic [4:0] OP_SLTU = 5'h08;
    localparam logic [4:0] OP_SLL  = 5'h09;
    localparam logic [4:0] OP_SRL  = 5'h0A;
    localparam logic [4:0] OP_SRA  = 5'h0B;
    localparam logic [4:0] OP_MULU = 5'h0C;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ready_en;
    logic             accept;
    logic [SHW-1:0]   mul_cnt;
    logic             mul_last;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             res_ovf;
    logic             res_err;

    // ready_en keeps in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign in_ready  = ready_en && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (mul_cnt == SHW'(WIDTH - 1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (alu_op == OP_MULU) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result; MULU is handled by the iterative datapath instead
    always_comb begin
        sum     = alu_a + alu_b;
        diff    = alu_a - alu_b;
        shamt   = alu_b[SHW-1:0];
        alu_res = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res = sum;
                res_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                res_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_NOR:  alu_res = ~(alu_a | alu_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            OP_SLL:  alu_res = alu_a << shamt;
            OP_SRL:  alu_res = alu_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
            OP_MULU: alu_res = '0;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_cnt <= '0;
        end else if (accept) begin
            if (alu_op == OP_MULU) begin
                acc     <= '0;
                mcand   <= alu_a;
                mplier  <= alu_b;
                mul_cnt <= '0;
            end else begin
                alu_out <= alu_res;
                zero    <= (alu_res == '0);
                ovf     <= res_ovf;
                err     <= res_err;
            end
        end else if (state == MUL) begin
            // One multiplier bit per cycle; only the low WIDTH product bits are kept
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 1'b1;
            if (mul_last) begin
                alu_out <= acc_next;
                zero    <= (acc_next == '0);
                ovf     <= 1'b0;
                err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=32: expected results are queued at
// accept and compared, with latency, when out_valid appears.
module tb_alu_pipe;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] alu_a = '0;
    logic [WIDTH-1:0] alu_b = '0;
    logic [4:0]       alu_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             ovf;
    logic             err;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             o;
        logic             e;
        int               lat;
    } exp_t;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   errorCount = 0;

    alu_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain operators, with the multiply done as a full-width product
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] r;
        logic [63:0] p;
        logic [4:0]  sh;
        r     = '0;
        sh    = b[4:0];
        e.o   = 1'b0;
        e.e   = 1'b0;
        e.lat = 1;
        case (op)
            5'h01: begin r = a + b; e.o = (a[31] == b[31]) && (r[31] != a[31]); end
            5'h02: begin r = a - b; e.o = (a[31] != b[31]) && (r[31] != a[31]); end
            5'h03: r = a & b;
            5'h04: r = a | b;
            5'h05: r = a ^ b;
            5'h06: r = ~(a | b);
            5'h07: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h08: r = (a < b) ? 32'd1 : 32'd0;
            5'h09: r = a << sh;
            5'h0A: r = a >> sh;
            5'h0B: begin
                r = a >> sh;
                for (int i = 0; i < 32; i++) if (i >= 32 - int'(sh)) r[i] = a[31];
            end
            5'h0C: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; e.lat = WIDTH + 1; end
            default: e.e = 1'b1;
        endcase
        e.res = r;
        e.z   = (r == 32'd0);
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int holdCycles);
        exp_t e;
        int   waitCnt;
        int   lat;
        @(negedge clk);
        waitCnt = 0;
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, "_ready"}, in_ready, 1'b1);
        alu_op    = op;
        alu_a     = a;
        alu_b     = b;
        in_valid  = 1'b1;
        out_ready = (holdCycles == 0);
        @(posedge clk);
        sbQueue.push_back(model(op, a, b));
        #1;
        in_valid = 1'b0;
        alu_a    = ~a;
        alu_b    = ~b;
        alu_op   = 5'h03;
        lat      = 1;
        @(negedge clk);
        if (!out_valid) checkOutput({tag, "_busy"}, in_ready, 1'b0);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_qsize"}, sbQueue.size(), 1);
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput({tag, "_lat"}, lat, e.lat);
            checkOutput({tag, "_out"}, alu_out, e.res);
            checkOutput({tag, "_zero"}, zero, e.z);
            checkOutput({tag, "_ovf"}, ovf, e.o);
            checkOutput({tag, "_err"}, err, e.e);
            for (int i = 0; i < holdCycles; i++) begin
                in_valid = 1'b1;
                alu_op   = 5'h01;
                @(negedge clk);
                checkOutput({tag, "_hold_v"}, out_valid, 1'b1);
                checkOutput({tag, "_hold_out"}, alu_out, e.res);
                checkOutput({tag, "_hold_rdy"}, in_ready, 1'b0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle_v"}, out_valid, 1'b0);
        checkOutput({tag, "_idle_rdy"}, in_ready, 1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sawValid;

        #23;
        checkOutput("rst_ready", in_ready, 1'b0);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_out", alu_out, 32'd0);
        checkOutput("rst_flags", {zero, ovf, err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_ready_pre_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_ready_post", in_ready, 1'b1);

        applyStimulus("add", 5'h01, 32'd2, 32'd2, 0);
        applyStimulus("sub_ovf", 5'h02, 32'h8000_0000, 32'd1, 0);
        applyStimulus("slt", 5'h07, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus("sltu", 5'h08, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus("mulu", 5'h0C, 32'd3, 32'd5, 0);
        applyStimulus("mulu_big", 5'h0C, 32'hFFFF_FFFF, 32'd2, 0);
        applyStimulus("add_hold", 5'h01, 32'd1, 32'd1, 5);
        applyStimulus("sra", 5'h0B, 32'h8000_0000, 32'h24, 0);
        applyStimulus("srl", 5'h0A, 32'h8000_0000, 32'h24, 0);
        applyStimulus("add_ovf", 5'h01, 32'h7FFF_FFFF, 32'd1, 0);
        applyStimulus("nor", 5'h06, 32'hF0F0_0000, 32'h0000_0F0F, 0);
        applyStimulus("sll", 5'h09, 32'h0000_0003, 32'hFFFF_FFE1, 0);
        applyStimulus("op00", 5'h00, 32'd5, 32'd6, 0);
        for (int i = 0; i < 10; i++) begin
            rop = 5'($urandom_range(1, 13));
            ra  = $urandom;
            rb  = $urandom;
            applyStimulus("rand", rop, ra, rb, i % 3);
        end

        applyStimulus("and_zero", 5'h03, 32'h0000_00F0, 32'h0000_000F, 0);
        @(negedge clk);
        alu_op   = 5'h0C;
        alu_a    = 32'd7;
        alu_b    = 32'd9;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_out", alu_out, 32'd0);
        checkOutput("midrst_zero", zero, 1'b0);
        checkOutput("midrst_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawValid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) sawValid = 1;
        end
        checkOutput("midrst_no_result", sawValid, 0);
        out_ready = 1'b0;

        applyStimulus("op1f", 5'h1F, 32'd12, 32'd34, 0);
        applyStimulus("xor", 5'h05, 32'hA5A5_A5A5, 32'hFFFF_0000, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
